alu_iterative: RTL

//  Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU control decoder.
//  ADD/SUB/XOR finish in one cycle; SRL uses an iterative 1-bit-per-cycle shifter to save area.

---
 rtl/alu_defs_pkg.sv | 15 +
 rtl/alu_iterative.sv | 103 ++++++++++
 2 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions.
//  - ALU_* : 4-bit ALUControl op codes, identical to the ALU control decoder's.
//  - ST_*  : FSM state encodings for alu_iterative.
package alu_defs;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_iterative.sv
// Execute-stage ALU with valid/ready on both sides.
//  ADD/SUB/XOR (and SRL by 0) complete in one cycle. SRL by n>=1 runs a
//  1-bit-per-cycle shifter and completes n+1 cycles after accept.
//  Unsupported codes (including X/Z) return result=0, zero=1, illegal=1.
// Ports:
//  clk, rst_n            clock, synchronous active-low reset
//  in_valid / in_ready   request handshake (in_ready high only in IDLE)
//  ALUControl, a, b      op code and operands, sampled only at accept
//  out_valid / out_ready result handshake (out_valid high only in DONE)
//  result, zero, illegal registered outputs, held stable in DONE
module alu_iterative
    import alu_defs::*;
#(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    logic [1:0]         state;
    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    quick;
    logic               quick_ill;
    logic [XLEN-1:0]    acc_next;

    assign shamt    = b[SHAMT_W-1:0];
    assign acc_next = acc >> 1;

    // Handshake outputs depend on state only.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Single-cycle result. SRL lands here only when shamt==0, so it passes a
    // through. X/Z codes fall to default and are reported as illegal.
    always_comb begin
        quick     = '0;
        quick_ill = 1'b0;
        case (ALUControl)
            ALU_ADD: quick = a + b;
            ALU_SUB: quick = a + ~b + 1'b1;
            ALU_XOR: quick = a ^ b;
            ALU_SRL: quick = a;
            default: quick_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            count   <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (ALUControl == ALU_SRL && shamt != '0) begin
                            acc   <= a;
                            count <= shamt;
                            state <= ST_SHIFT;
                        end else begin
                            result  <= quick;
                            zero    <= (quick == '0);
                            illegal <= quick_ill;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc   <= acc_next;
                    count <= count - 1'b1;
                    // Last shift: publish the shifted value directly.
                    if (count == SHAMT_W'(1)) begin
                        result  <= acc_next;
                        zero    <= (acc_next == '0);
                        illegal <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
